eclk_periph_sync: RTL and testbench

- Consumer end of the E-clock enable bus. Takes the 10-phase one-hot eclk enables (phase 0..9 per 0.709 MHz E period, clk domain) and runs 6800-style synchronous peripheral cycles (VPA/VMA style) for the CIA address space.
- Admits a CPU request only at a fixed E phase, asserts VMA, and fires one read or write strobe to the peripheral at a fixed late phase. It then returns latched data and a one-cycle acknowledge to the CPU bus interface.
- Also regenerates the E level signal for peripherals.

---
 rtl/eclk_periph_sync_pkg.sv | 15 +
 rtl/eclk_periph_sync_e_level_gen.sv | 28 ++
 rtl/eclk_periph_sync.sv | 126 ++++++++++++
 tb/tb_eclk_periph_sync.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eclk_periph_sync_pkg.sv
// Shared constants and state encoding for the E-clock peripheral cycle engine.
package eclk_periph_sync_pkg;

    localparam int unsigned E_PHASES     = 10;
    localparam int unsigned E_HIGH_FIRST = 6;
    localparam int unsigned E_HIGH_LAST  = 9;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        ACK,
        HOLD
    } state_t;

endpackage

// File: rtl/eclk_periph_sync_e_level_gen.sv
// Regenerates the E clock level from the one-hot phase enables.
module e_level_gen
    import eclk_periph_sync_pkg::*;
(
    input  logic                clk,
    input  logic                _reset,
    input  logic [E_PHASES-1:0] eclk,
    output logic                e
);

    logic e_q, e_d;

    // Registered, so sampling phases 5..8 yields e high during phases 6..9.
    always_comb begin
        e_d = |eclk[E_HIGH_LAST-1:E_HIGH_FIRST-1];
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            e_q <= 1'b0;
        end else begin
            e_q <= e_d;
        end
    end

    assign e = e_q;

endmodule

// File: rtl/eclk_periph_sync.sv
// Consumer of the E-clock enable bus: runs 6800-style synchronous peripheral cycles.
module eclk_periph_sync
    import eclk_periph_sync_pkg::*;
#(
    parameter int unsigned DW           = 8,
    parameter int unsigned SYNC_PHASE   = 2,
    parameter int unsigned STROBE_PHASE = 9
) (
    input  logic                clk,
    input  logic                _reset,
    input  logic [E_PHASES-1:0] eclk,
    input  logic                cpu_req,
    input  logic                cpu_rd,
    input  logic [DW-1:0]       cpu_wdata,
    input  logic [DW-1:0]       cia_rdata,
    output logic                vma,
    output logic                e,
    output logic                cia_rd_stb,
    output logic                cia_wr_stb,
    output logic [DW-1:0]       cia_wdata,
    output logic [DW-1:0]       cpu_rdata,
    output logic                cpu_ack,
    output logic                busy
);

    state_t        state_q, state_d;
    logic          dir_rd_q, dir_rd_d;
    logic          rd_stb_q, rd_stb_d;
    logic          wr_stb_q, wr_stb_d;
    logic          ack_q, ack_d;
    logic          vma_q, vma_d;
    logic          busy_q, busy_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          strobing;

    e_level_gen u_e_level_gen (
        .clk    (clk),
        ._reset (_reset),
        .eclk   (eclk),
        .e      (e)
    );

    always_comb begin
        state_d  = state_q;
        dir_rd_d = dir_rd_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rd_stb_d = 1'b0;
        wr_stb_d = 1'b0;
        ack_d    = 1'b0;
        strobing = rd_stb_q | wr_stb_q;

        case (state_q)
            IDLE: begin
                if (cpu_req && eclk[SYNC_PHASE]) begin
                    state_d  = ACTIVE;
                    dir_rd_d = cpu_rd;
                    wdata_d  = cpu_wdata;
                end
            end
            ACTIVE: begin
                // Completion keys off the strobe itself, so an ack can never appear without one.
                if (strobing) begin
                    state_d = ACK;
                    ack_d   = 1'b1;
                    if (dir_rd_q) begin
                        rdata_d = cia_rdata;
                    end
                end else if (!cpu_req) begin
                    state_d = IDLE;
                end else if (eclk[STROBE_PHASE-1]) begin
                    rd_stb_d = dir_rd_q;
                    wr_stb_d = !dir_rd_q;
                end
            end
            ACK: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (!cpu_req) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        vma_d  = (state_d == ACTIVE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_q  <= IDLE;
            dir_rd_q <= 1'b0;
            rd_stb_q <= 1'b0;
            wr_stb_q <= 1'b0;
            ack_q    <= 1'b0;
            vma_q    <= 1'b0;
            busy_q   <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            dir_rd_q <= dir_rd_d;
            rd_stb_q <= rd_stb_d;
            wr_stb_q <= wr_stb_d;
            ack_q    <= ack_d;
            vma_q    <= vma_d;
            busy_q   <= busy_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

    assign vma        = vma_q;
    assign cia_rd_stb = rd_stb_q;
    assign cia_wr_stb = wr_stb_q;
    assign cia_wdata  = wdata_q;
    assign cpu_rdata  = rdata_q;
    assign cpu_ack    = ack_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_eclk_periph_sync.sv
// Self-checking bench for eclk_periph_sync: vector table plus scoreboard of completed cycles.
module tb_eclk_periph_sync;

    localparam int DW     = 8;
    localparam int SYNC   = 2;
    localparam int STROBE = 9;

    logic          clk;
    logic          _reset;
    logic [9:0]    eclk;
    logic          cpu_req;
    logic          cpu_rd;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cia_rdata;
    logic          vma;
    logic          e;
    logic          cia_rd_stb;
    logic          cia_wr_stb;
    logic [DW-1:0] cia_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          busy;

    eclk_periph_sync #(
        .DW           (DW),
        .SYNC_PHASE   (SYNC),
        .STROBE_PHASE (STROBE)
    ) dut (
        .clk        (clk),
        ._reset     (_reset),
        .eclk       (eclk),
        .cpu_req    (cpu_req),
        .cpu_rd     (cpu_rd),
        .cpu_wdata  (cpu_wdata),
        .cia_rdata  (cia_rdata),
        .vma        (vma),
        .e          (e),
        .cia_rd_stb (cia_rd_stb),
        .cia_wr_stb (cia_wr_stb),
        .cia_wdata  (cia_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ack    (cpu_ack),
        .busy       (busy)
    );

    typedef struct packed {
        logic          rd;
        logic [DW-1:0] wd;
        logic [DW-1:0] rd_exp;
    } sb_t;

    typedef struct {
        logic          rd;
        logic [DW-1:0] wd;
        logic [DW-1:0] rv;
        int            p;
        int            hold;
    } vec_t;

    sb_t           sb_q[$];
    vec_t          vecs[6];
    int            errors = 0;
    int            checks = 0;
    int            ph;
    logic          eclk_zero;
    logic [DW-1:0] rd_val;
    logic [DW-1:0] model_rdata;
    int            n_stb = 0;
    int            n_ack = 0;
    logic          prev_stb = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Phase generator: advances one phase per clk, with the rdata bus only valid in phase 9.
    initial begin
        ph        = 9;
        eclk      = '0;
        cia_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            ph        = (ph + 1) % 10;
            eclk      = eclk_zero ? 10'b0 : (10'b1 << ph);
            cia_rdata = (ph == 9) ? rd_val : ~rd_val;
        end
    end

    // Scoreboard consumer: every ack must match the oldest outstanding request.
    initial begin
        forever begin
            @(negedge clk);
            if (cia_rd_stb || cia_wr_stb) begin
                n_stb++;
                chk("stb_excl", 32'(cia_rd_stb & cia_wr_stb), 32'd0);
            end
            if (cpu_ack) begin
                sb_t ent;
                n_ack++;
                chk("ack_after_stb", 32'(prev_stb), 32'd1);
                chk("sb_pending", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    ent = sb_q.pop_front();
                    chk("ack_rdata", 32'(cpu_rdata), 32'(ent.rd_exp));
                    if (!ent.rd) begin
                        chk("ack_wdata", 32'(cia_wdata), 32'(ent.wd));
                    end
                end
            end
            prev_stb = cia_rd_stb | cia_wr_stb;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_phase(input int p);
        int n;
        n = 0;
        while (ph != p && n < 12) begin
            tick();
            n++;
        end
        chk("wait_phase", 32'(ph), 32'(p));
    endtask

    task automatic run_txn(input logic rd, input logic [DW-1:0] wd, input logic [DW-1:0] rv,
                           input int p, input int hold, input string tag);
        int s_lat, a_lat, vcnt, scnt, hvma, s0, a0, exp_s;
        s_lat = -1;
        a_lat = -1;
        vcnt  = 0;
        scnt  = 0;
        hvma  = 0;
        s0    = n_stb;
        a0    = n_ack;
        wait_phase(p);
        cpu_req   = 1'b1;
        cpu_rd    = rd;
        cpu_wdata = wd;
        rd_val    = rv;
        sb_q.push_back({rd, wd, rd ? rv : model_rdata});
        if (rd) model_rdata = rv;
        exp_s = ((SYNC - p + 10) % 10) + (STROBE - SYNC);
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (vma) vcnt++;
            if (cia_rd_stb || cia_wr_stb) begin
                scnt++;
                if (s_lat < 0) s_lat = k;
                chk({tag, "_dir"}, 32'({cia_rd_stb, cia_wr_stb}), rd ? 32'd2 : 32'd1);
                if (!rd) chk({tag, "_cia_wdata"}, 32'(cia_wdata), 32'(wd));
            end
            if (cpu_ack) begin
                a_lat = k;
                break;
            end
        end
        for (int h = 0; h < hold; h++) begin
            tick();
            if (vma) hvma++;
        end
        cpu_req = 1'b0;
        chk({tag, "_stb_lat"}, 32'(s_lat), 32'(exp_s));
        chk({tag, "_ack_lat"}, 32'(a_lat), 32'(exp_s + 1));
        chk({tag, "_vma_cycles"}, 32'(vcnt), 32'(STROBE - SYNC));
        chk({tag, "_stb_count"}, 32'(scnt), 32'd1);
        tick();
        tick();
        chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
        chk({tag, "_stb_total"}, 32'(n_stb - s0), 32'd1);
        chk({tag, "_ack_total"}, 32'(n_ack - a0), 32'd1);
        if (hold > 0) chk({tag, "_hold_vma"}, 32'(hvma), 32'd0);
    endtask

    initial begin
        int s0, a0, v;
        vecs[0] = '{rd: 1'b1, wd: 8'h00, rv: 8'hA5, p: 1, hold: 0};
        vecs[1] = '{rd: 1'b0, wd: 8'h3C, rv: 8'h11, p: 3, hold: 0};
        vecs[2] = '{rd: 1'b1, wd: 8'h00, rv: 8'h5A, p: 1, hold: 30};
        vecs[3] = '{rd: 1'b0, wd: 8'hC3, rv: 8'h22, p: 2, hold: 0};
        vecs[4] = '{rd: 1'b1, wd: 8'h00, rv: 8'h0F, p: 7, hold: 0};
        vecs[5] = '{rd: 1'b0, wd: 8'h81, rv: 8'h33, p: 0, hold: 0};

        _reset      = 1'b0;
        cpu_req     = 1'b0;
        cpu_rd      = 1'b0;
        cpu_wdata   = '0;
        rd_val      = '0;
        eclk_zero   = 1'b0;
        model_rdata = '0;
        repeat (3) tick();
        chk("rst_vma", 32'(vma), 32'd0);
        chk("rst_e", 32'(e), 32'd0);
        chk("rst_rd_stb", 32'(cia_rd_stb), 32'd0);
        chk("rst_wr_stb", 32'(cia_wr_stb), 32'd0);
        chk("rst_ack", 32'(cpu_ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cia_wdata", 32'(cia_wdata), 32'd0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        _reset = 1'b1;

        repeat (3) tick();
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("e_level", 32'(e), 32'(ph >= 6 && ph <= 9));
        end

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].rd, vecs[i].wd, vecs[i].rv, vecs[i].p, vecs[i].hold, $sformatf("vec%0d", i));
        end

        // Abort: request dropped in phase 6 of an admitted write.
        s0 = n_stb;
        a0 = n_ack;
        wait_phase(1);
        cpu_req   = 1'b1;
        cpu_rd    = 1'b0;
        cpu_wdata = 8'h77;
        wait_phase(6);
        chk("abort_vma_before", 32'(vma), 32'd1);
        cpu_req = 1'b0;
        tick();
        chk("abort_vma_after", 32'(vma), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (15) tick();
        chk("abort_no_stb", 32'(n_stb - s0), 32'd0);
        chk("abort_no_ack", 32'(n_ack - a0), 32'd0);

        // Reset pulsed in phase 7 of an active read.
        wait_phase(1);
        cpu_req = 1'b1;
        cpu_rd  = 1'b1;
        rd_val  = 8'h99;
        wait_phase(7);
        chk("rstmid_vma_before", 32'(vma), 32'd1);
        chk("rstmid_e_before", 32'(e), 32'd1);
        #1;
        _reset = 1'b0;
        #1;
        chk("rstmid_vma", 32'(vma), 32'd0);
        chk("rstmid_e", 32'(e), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_cia_wdata", 32'(cia_wdata), 32'd0);
        chk("rstmid_cpu_rdata", 32'(cpu_rdata), 32'd0);
        cpu_req = 1'b0;
        tick();
        _reset      = 1'b1;
        model_rdata = '0;
        s0          = n_stb;
        a0          = n_ack;
        repeat (20) tick();
        chk("rstmid_no_stb", 32'(n_stb - s0), 32'd0);
        chk("rstmid_no_ack", 32'(n_ack - a0), 32'd0);

        // Generator stalled: no E level and no admissions.
        eclk_zero = 1'b1;
        tick();
        tick();
        chk("zero_e", 32'(e), 32'd0);
        cpu_req = 1'b1;
        cpu_rd  = 1'b1;
        v       = 0;
        s0      = n_stb;
        repeat (25) begin
            tick();
            if (vma || e) v++;
        end
        chk("zero_no_vma", 32'(v), 32'd0);
        chk("zero_no_stb", 32'(n_stb - s0), 32'd0);
        cpu_req   = 1'b0;
        eclk_zero = 1'b0;

        run_txn(1'b0, 8'h5E, 8'h44, 2, 0, "post");

        repeat (4) tick();
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
